// File: rtl/fmac_pkg.sv
// Shared types and sizing helpers for the fmac_seq multiply-accumulate sequencer.
package fmac_pkg;

  // Top-level control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } fmac_state_e;

  // FloPoCo word: 2-bit exception, sign, exponent, fraction.
  function automatic int word_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fmac_lat_pipe.sv
// LAT-deep valid/index delay line; tags results coming back from an external
// pipelined core with the term index they belong to.
module fmac_lat_pipe #(
  parameter int LAT = 1,
  parameter int IW  = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  logic [LAT-1:0] v_q;
  logic [IW-1:0]  idx_q [LAT];

  // Shift valid and index one stage per cycle; clr drops everything in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      v_q[0]   <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        v_q[i]   <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/fmac_seq.sv
// Self-sequencing dot-product engine: result = acc0 + sum(a[k]*b[k]) using one
// external FloPoCo multiplier and one external FloPoCo adder.
//
// Handshake: start is sampled only in IDLE; an accepted start latches the
// operand vectors and acc0 (init_val, or the held result when use_prev=1).
// busy is high from the next cycle through the done cycle; done is a one-cycle
// pulse during which result is valid, and result holds until the next done.
// start seen while busy is ignored, never queued.
module fmac_seq
  import fmac_pkg::*;
#(
  parameter int WE      = 8,
  parameter int WF      = 23,
  parameter int N_TERMS = 4,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1,
  localparam int W      = word_w(WE, WF),
  localparam int CW     = cnt_w(N_TERMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 use_prev,
  input  logic [W-1:0]         init_val,
  input  logic [N_TERMS*W-1:0] a_vec,
  input  logic [N_TERMS*W-1:0] b_vec,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         result,
  output logic [W-1:0]         fmul_x,
  output logic [W-1:0]         fmul_y,
  input  logic [W-1:0]         fmul_r,
  output logic [W-1:0]         fadd_x,
  output logic [W-1:0]         fadd_y,
  input  logic [W-1:0]         fadd_r,
  output fmac_state_e          dbg_state
);

  fmac_state_e state_q, state_d;

  logic [W-1:0]       a_q    [N_TERMS];
  logic [W-1:0]       b_q    [N_TERMS];
  logic [W-1:0]       prod_q [N_TERMS];
  logic [N_TERMS-1:0] pb_valid_q;
  logic [CW-1:0]      mul_cnt_q;
  logic [CW-1:0]      add_cnt_q;
  logic               add_wait_q;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       result_q;

  logic          accept;
  logic          mul_issue;
  logic          add_issue;
  logic [W-1:0]  mul_a, mul_b;
  logic [W-1:0]  prod_sel;
  logic          prod_rdy;
  logic          mul_ret_v;
  logic [CW-1:0] mul_ret_idx;
  logic          add_ret_v;
  logic [CW-1:0] add_ret_idx;
  logic          last_capture;

  assign accept = (state_q == ST_IDLE) && start;

  // Multiplies issue back-to-back until every pair has gone out.
  assign mul_issue = (state_q == ST_RUN) && (mul_cnt_q != CW'(N_TERMS));

  // Pick the current mul operands and the product the next add needs.
  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    prod_sel = '0;
    prod_rdy = 1'b0;
    for (int k = 0; k < N_TERMS; k++) begin
      if (mul_cnt_q == CW'(k)) begin
        mul_a = a_q[k];
        mul_b = b_q[k];
      end
      if (add_cnt_q == CW'(k)) begin
        prod_sel = prod_q[k];
        prod_rdy = pb_valid_q[k];
      end
    end
  end

  // An add goes out once its product is buffered and the previous sum is in acc.
  assign add_issue = (state_q == ST_RUN) && (add_cnt_q != CW'(N_TERMS)) &&
                     prod_rdy && !add_wait_q;

  assign last_capture = (state_q == ST_RUN) && add_ret_v &&
                        (add_ret_idx == CW'(N_TERMS - 1));

  fmac_lat_pipe #(.LAT(MUL_LAT), .IW(CW)) u_mul_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (mul_issue),
    .in_idx    (mul_cnt_q),
    .out_valid (mul_ret_v),
    .out_idx   (mul_ret_idx)
  );

  fmac_lat_pipe #(.LAT(ADD_LAT), .IW(CW)) u_add_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (add_issue),
    .in_idx    (add_cnt_q),
    .out_valid (add_ret_v),
    .out_idx   (add_ret_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_capture) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, counters, product buffer and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TERMS; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        prod_q[k] <= '0;
      end
      pb_valid_q <= '0;
      mul_cnt_q  <= '0;
      add_cnt_q  <= '0;
      add_wait_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_TERMS; k++) begin
        a_q[k] <= a_vec[k*W +: W];
        b_q[k] <= b_vec[k*W +: W];
      end
      acc_q      <= use_prev ? result_q : init_val;
      pb_valid_q <= '0;
      mul_cnt_q  <= '0;
      add_cnt_q  <= '0;
      add_wait_q <= 1'b0;
    end else begin
      if (mul_issue) mul_cnt_q <= mul_cnt_q + 1'b1;
      if ((state_q == ST_RUN) && mul_ret_v) begin
        for (int k = 0; k < N_TERMS; k++) begin
          if (mul_ret_idx == CW'(k)) begin
            prod_q[k]     <= fmul_r;
            pb_valid_q[k] <= 1'b1;
          end
        end
      end
      if (add_issue) begin
        add_cnt_q  <= add_cnt_q + 1'b1;
        add_wait_q <= 1'b1;
      end
      if ((state_q == ST_RUN) && add_ret_v) begin
        acc_q      <= fadd_r;
        add_wait_q <= 1'b0;
        if (last_capture) result_q <= fadd_r;
      end
    end
  end

  assign fmul_x    = mul_issue ? mul_a : '0;
  assign fmul_y    = mul_issue ? mul_b : '0;
  assign fadd_x    = add_issue ? acc_q : '0;
  assign fadd_y    = add_issue ? prod_sel : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fmac_seq.md
# fmac_seq

Self-sequencing floating-point multiply-accumulate engine computing result = acc0 + Σ a[k]·b[k] over N_TERMS FloPoCo-format operand pairs. It drives one external FloPoCo multiplier and one external FloPoCo adder, and tracks their configurable pipeline latencies internally. It is a start/done-handshaked successor to the schedule-driven MAC: it does not need per-state strobes from the HLS FSM and can chain one dot product onto the previous result.

## Interface
- WE, 8: exponent width.
- WF, 23: fraction width. Word width is W = WE+WF+3 (2-bit exception field, sign, exponent, fraction).
- N_TERMS, 4: number of product terms. Must be ≥1.
- MUL_LAT, 1: multiplier latency in cycles. Must be ≥1.
- ADD_LAT, 1: adder latency in cycles. Must be ≥1.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  launches an operation. Sampled only in IDLE.
- use_prev  in  1  sampled with start. 1 selects the held result as acc0; 0 selects init_val.
- init_val  in  W  initial accumulator value.
- a_vec, b_vec  in  N_TERMS·W  operand vectors. Term k occupies bits [k·W +: W].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  W  final sum. Holds its value until the next done.
- fmul_x, fmul_y  out  W  multiplier operands.
- fmul_r  in  W  multiplier result.
- fadd_x, fadd_y  out  W  adder operands.
- fadd_r  in  W  adder result.

## Operation
- Core contract: operands driven during cycle c produce a result valid during cycle c+MUL_LAT (multiplier) or c+ADD_LAT (adder).
- Start capture: on accepted start (cycle 0), the block latches a_vec, b_vec, and acc0 (init_val or result, per use_prev). Inputs may change afterwards.
- Multiply issue: pair k is driven on fmul_x/fmul_y during cycle 1+k, for k = 0..N_TERMS-1, back-to-back.
- Valid tracking: a MUL_LAT-deep valid delay line tags fmul_r. Product k is written into prod_buf[k] (depth N_TERMS) during cycle 1+k+MUL_LAT.
- Add issue: add k drives fadd_x = acc (acc0 for k=0), fadd_y = prod_buf[k]. It issues in the first cycle in which product k is buffered and the previous add's result has been captured into acc.
- Accumulate: fadd_r is captured into acc during cycle issue+ADD_LAT. After the last add, acc is copied to result and done pulses the following cycle.
- States:
  - IDLE → RUN on start.
  - RUN contains the independent mul counter and add counter/wait counter.
  - RUN → FIN when the last fadd_r is captured.
  - FIN → IDLE after one cycle. done=1 in FIN.
- Operand idle value: fmul_x/y and fadd_x/y are 0 in every cycle they are not issuing.
- No arithmetic is performed in this block. Values pass through unchanged.

## Timing
- Add k issue cycle: 2+MUL_LAT+k·(ADD_LAT+1).
- done cycle: 2+MUL_LAT+N_TERMS·(ADD_LAT+1). With defaults, that is cycle 11.
- Reset values:
  - All outputs, including result, are 0.
  - State is IDLE.
  - Counters, prod_buf valid bits, and the delay line are cleared.
- start while busy or in FIN: ignored. No queueing.
- start in the same cycle as rst: rst wins.
- rst mid-operation:
  - Returns to IDLE next cycle, with no done pulse.
  - In-flight core results arriving afterwards are discarded via the cleared delay line.
- N_TERMS=1: a single mul and a single add. done at cycle 3+MUL_LAT+ADD_LAT.
- use_prev=1 after reset uses result=0.
- Back-to-back operations: start may be asserted in the cycle after done (IDLE). The new acc0 sees the just-updated result.

## Structure
- fmac_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - the localparam function word_w(WE,WF) = WE+WF+3;
  - the counter-width helper $clog2(N_TERMS+1).
- One sub-module, fmac_lat_pipe: a parameterised LAT-deep valid/index shift register with synchronous clear. It is instantiated twice, once for the multiplier path and once for the adder path.
- FloPoCo cores stay external, at the same level as the block.

## Test plan
- Defaults, using behavioural core models. a=[1,2,3,4], b=[1,1,1,1], init_val=0.5, use_prev=0 → done in cycle 11, result=10.5. Adds issue in cycles 3,5,7,9.
- Chaining: immediately repeat with use_prev=1, a=b=[1,1,1,1] → result=14.5.
- MUL_LAT=3, ADD_LAT=2, N_TERMS=3, all products 2.0, init 0 → done in cycle 14, result=6.0.
- N_TERMS=1, a=b=3.0, init_val=1.0 → done in cycle 5, result=10.0. Exactly one fmul issue and one fadd issue.
- Reset asserted in cycle 6 of the default run → no done. All operand outputs are 0 from cycle 7. A following run gives the correct result.
- start pulsed every cycle during a run → exactly one done, busy stays continuous, and no operand re-latching occurs.
